// File: rtl/boot_pkg.sv
// Shared constants and state encoding for the UART boot loader.
package boot_pkg;

  localparam logic [7:0] SYNC = 8'h55;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {
    S_PROMPT = 3'd0,
    S_SYNC   = 3'd1,
    S_LEN_HI = 3'd2,
    S_LEN_LO = 3'd3,
    S_DATA   = 3'd4,
    S_CSUM   = 3'd5,
    S_REPLY  = 3'd6,
    S_RUN    = 3'd7
  } state_t;

  // Keep only the length bits that can address the RAM.
  function automatic logic [15:0] len_mask(input logic [15:0] len, input int unsigned aw);
    logic [15:0] m;
    m = 16'hFFFF;
    if (aw < 16) m = (16'h1 << aw) - 16'h1;
    return len & m;
  endfunction

endpackage

// File: rtl/boot_ctrl_if.sv
// Bundle of UART byte, RAM write and CPU control signals around boot_ctrl.
//
// Handshakes: rx_valid is a one-cycle strobe that qualifies rx_data; there is
// no back-pressure, a byte offered while the loader cannot take it is lost.
// tx_start is a one-cycle strobe that qualifies tx_data and is only raised
// after a cycle in which tx_busy was low; tx_busy is a level from the UART.
// ram_we qualifies ram_addr/ram_wdata for exactly the cycle it is high.
interface boot_ctrl_if #(
  parameter int ADDR_W = 16
);
  import boot_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              boot_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              cpu_rst_n;
  logic              loading;
  logic              err;
  state_t            state;     // debug view of the loader FSM

  modport slave (
    input  rx_data, rx_valid, tx_busy, boot_req, cpu_we, cpu_addr, cpu_wdata,
    output tx_data, tx_start, ram_we, ram_addr, ram_wdata, cpu_rst_n, loading,
           err, state
  );

  modport master (
    output rx_data, rx_valid, tx_busy, boot_req, cpu_we, cpu_addr, cpu_wdata,
    input  tx_data, tx_start, ram_we, ram_addr, ram_wdata, cpu_rst_n, loading,
           err, state
  );

endinterface

// File: rtl/boot_ctrl_timeout.sv
// Inter-byte idle counter; flags expiry after TIMEOUT_CYC enabled cycles.
module boot_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] timer_q, timer_d;

  // Clear wins over counting so a byte arriving on the last cycle still counts.
  always_comb begin
    timer_d = timer_q;
    if (clr_i)     timer_d = '0;
    else if (en_i) timer_d = timer_q + TW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end

  assign expired_o = en_i && (timer_q == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/boot_ctrl.sv
// UART program loader: receives a framed image into RAM, replies ACK/NAK and
// then hands the RAM write port and CPU reset to the processor.
module boot_ctrl
  import boot_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                TIMEOUT_CYC = 1000000,
  parameter logic [7:0]        PROMPT      = 8'h3E
) (
  input  logic       clk,
  input  logic       rst_n,
  boot_ctrl_if.slave bus
);

  state_t            state_q;
  logic              tx_start_q;
  logic [7:0]        tx_data_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_wdata_q;
  logic              cpu_rst_n_q;
  logic              err_q;
  logic              ack_q;
  logic [15:0]       len_q;
  logic [15:0]       count_q;
  logic [7:0]        csum_q;

  logic              in_frame;
  logic              expired;
  logic              run;
  logic [15:0]       count_inc;

  // Only the in-frame states are subject to the inter-byte timeout.
  assign in_frame  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);
  assign run       = (state_q == S_RUN);
  assign count_inc = count_q + 16'd1;

  boot_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (bus.rx_valid || !in_frame),
    .en_i      (in_frame),
    .expired_o (expired)
  );

  // Loader FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PROMPT;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'h00;
      cpu_rst_n_q <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      len_q       <= 16'h0000;
      count_q     <= 16'h0000;
      csum_q      <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      ram_we_q   <= 1'b0;
      case (state_q)
        S_PROMPT: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= PROMPT;
            state_q    <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (bus.rx_valid && (bus.rx_data == SYNC)) state_q <= S_LEN_HI;
        end
        S_LEN_HI: begin
          if (bus.rx_valid) begin
            len_q[15:8] <= bus.rx_data;
            state_q     <= S_LEN_LO;
          end else if (expired) begin
            ack_q   <= 1'b0;
            state_q <= S_REPLY;
          end
        end
        S_LEN_LO: begin
          if (bus.rx_valid) begin
            len_q[7:0] <= bus.rx_data;
            count_q    <= 16'h0000;
            csum_q     <= 8'h00;
            if (len_mask({len_q[15:8], bus.rx_data}, ADDR_W) == 16'h0000) state_q <= S_CSUM;
            else                                                          state_q <= S_DATA;
          end else if (expired) begin
            ack_q   <= 1'b0;
            state_q <= S_REPLY;
          end
        end
        S_DATA: begin
          if (bus.rx_valid) begin
            ram_we_q    <= 1'b1;
            ram_addr_q  <= BASE_ADDR + ADDR_W'(count_q);
            ram_wdata_q <= bus.rx_data;
            csum_q      <= csum_q + bus.rx_data;
            count_q     <= count_inc;
            if (count_inc == len_mask(len_q, ADDR_W)) state_q <= S_CSUM;
          end else if (expired) begin
            ack_q   <= 1'b0;
            state_q <= S_REPLY;
          end
        end
        S_CSUM: begin
          if (bus.rx_valid) begin
            ack_q   <= (bus.rx_data == csum_q);
            state_q <= S_REPLY;
          end else if (expired) begin
            ack_q   <= 1'b0;
            state_q <= S_REPLY;
          end
        end
        S_REPLY: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= ack_q ? ACK : NAK;
            err_q      <= !ack_q;
            state_q    <= ack_q ? S_RUN : S_SYNC;
          end
        end
        S_RUN: begin
          if (bus.boot_req) begin
            cpu_rst_n_q <= 1'b0;
            state_q     <= S_PROMPT;
          end else begin
            cpu_rst_n_q <= 1'b1;
          end
        end
        default: state_q <= S_PROMPT;
      endcase
    end
  end

  // RAM port owner follows the registered state, so ownership only changes
  // on a clock edge and no single write is split between owners.
  assign bus.ram_we    = run ? bus.cpu_we    : ram_we_q;
  assign bus.ram_addr  = run ? bus.cpu_addr  : ram_addr_q;
  assign bus.ram_wdata = run ? bus.cpu_wdata : ram_wdata_q;

  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.cpu_rst_n = cpu_rst_n_q;
  assign bus.err       = err_q;
  assign bus.loading   = !run;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Bench for boot_ctrl: frame download, checksum errors, timeout, run-mode
// hand-over, boot request and asynchronous reset.
module tb_boot_ctrl;
  import boot_pkg::*;

  localparam int         ADDR_W = 16;
  localparam int         TO     = 50;
  localparam logic [7:0] PR     = 8'h3E;
  localparam logic [7:0] B_ACK  = 8'h06;
  localparam logic [7:0] B_NAK  = 8'h15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  boot_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  boot_ctrl #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (16'h0000),
    .TIMEOUT_CYC (TO),
    .PROMPT      (PR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ADDR_W+7:0] exp_ram_q[$];
  logic [7:0]        exp_tx_q[$];
  logic [7:0]        pl_q[$];

  // ---------------- UART transmitter model ----------------
  logic force_busy = 1'b1;
  logic tx_seen;
  int   busy_cnt   = 0;

  always @(posedge clk) begin
    tx_seen = bus.tx_start;
    #1;
    if (tx_seen) busy_cnt = $urandom_range(2, 6);
    else if (busy_cnt > 0) busy_cnt--;
    bus.tx_busy = force_busy || (busy_cnt != 0);
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_we) begin
        n_tests++;
        if (exp_ram_q.size() == 0) begin
          n_fail++;
          $display("FAIL ram_write: got addr=%h data=%h, required no write", bus.ram_addr, bus.ram_wdata);
        end else begin
          logic [ADDR_W+7:0] e;
          e = exp_ram_q.pop_front();
          if ({bus.ram_addr, bus.ram_wdata} !== e) begin
            n_fail++;
            $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                     bus.ram_addr, bus.ram_wdata, e[ADDR_W+7:8], e[7:0]);
          end
        end
      end
      if (bus.tx_start) begin
        n_tests++;
        if (exp_tx_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_byte: got %h, required no transmit", bus.tx_data);
        end else begin
          logic [7:0] t;
          t = exp_tx_q.pop_front();
          if (bus.tx_data !== t) begin
            n_fail++;
            $display("FAIL tx_byte: got %h, required %h", bus.tx_data, t);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input string name, input int max_cyc, output int used);
    used = 0;
    while (exp_tx_q.size() != 0 && used < max_cyc) begin
      @(negedge clk);
      used++;
    end
    n_tests++;
    if (exp_tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_tx_wait: %0d bytes still pending after %0d cycles, required 0",
               name, exp_tx_q.size(), max_cyc);
      exp_tx_q.delete();
    end
    tick();
  endtask

  task automatic wait_cpu_run(input string name);
    int k;
    k = 0;
    while (bus.cpu_rst_n !== 1'b1 && k < 4) begin
      tick();
      k++;
    end
    n_tests++;
    if (bus.cpu_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_cpu_rst_n: got %b, required 1", name, bus.cpu_rst_n);
    end
  endtask

  // Sends sync, length, pl_q and the given checksum back-to-back; the
  // expected writes and reply are derived from pl_q here.
  task automatic send_frame(input string name, input logic [7:0] cs);
    logic [7:0]  sum;
    logic [15:0] n;
    int          used;
    sum = 8'h00;
    n   = 16'(pl_q.size());
    foreach (pl_q[i]) begin
      sum = sum + pl_q[i];
      exp_ram_q.push_back({16'(i), pl_q[i]});
    end
    exp_tx_q.push_back((sum == cs) ? B_ACK : B_NAK);
    send_byte(8'h55);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    foreach (pl_q[i]) send_byte(pl_q[i]);
    send_byte(cs);
    wait_tx(name, 100, used);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] obs, expv;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs  = {bus.tx_start, bus.tx_data, bus.ram_we, bus.cpu_rst_n, bus.err, bus.loading, bus.state};
    expv = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, S_PROMPT};
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL reset_values: got %h, required %h", obs, expv);
    end
    tick();
    rst_n = 1'b1;
    // transmitter busy: no prompt may go out
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.tx_start !== 1'b0 || bus.state !== S_PROMPT) begin
        n_fail++;
        $display("FAIL prompt_while_busy: got tx_start=%b state=%0d, required 0/%0d",
                 bus.tx_start, bus.state, S_PROMPT);
      end
    end
    tick();
    exp_tx_q.push_back(PR);
    force_busy = 1'b0;
    begin
      int used;
      wait_tx("prompt", 20, used);
    end
    @(negedge clk);
    n_tests++;
    if (bus.state !== S_SYNC || bus.cpu_rst_n !== 1'b0 || bus.loading !== 1'b1) begin
      n_fail++;
      $display("FAIL after_prompt: got state=%0d cpu_rst_n=%b loading=%b, required %0d/0/1",
               bus.state, bus.cpu_rst_n, bus.loading, S_SYNC);
    end
    tick();
  endtask

  task automatic test_good_frame();
    // CPU writes while loading must not reach the RAM
    bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0009; bus.cpu_wdata = 8'hEE;
    repeat (3) tick();
    bus.cpu_we = 1'b0;
    // a stray byte before sync is ignored
    send_byte(8'hA0);
    pl_q = '{8'h11, 8'h22, 8'h33};
    send_frame("good", 8'h66);
    @(negedge clk);
    n_tests++;
    if (bus.err !== 1'b0 || bus.state !== S_RUN || bus.loading !== 1'b0) begin
      n_fail++;
      $display("FAIL good_status: got err=%b state=%0d loading=%b, required 0/%0d/0",
               bus.err, bus.state, bus.loading, S_RUN);
    end
    tick();
    wait_cpu_run("good");
    exp_ram_q.push_back({16'h0005, 8'h5A});
    bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0005; bus.cpu_wdata = 8'h5A;
    tick();
    bus.cpu_we = 1'b0;
    tick();
  endtask

  task automatic test_boot_req();
    int used;
    exp_tx_q.push_back(PR);
    bus.boot_req = 1'b1;
    tick();
    bus.boot_req = 1'b0;
    bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0007; bus.cpu_wdata = 8'h77;
    @(negedge clk);
    n_tests++;
    if (bus.cpu_rst_n !== 1'b0 || bus.loading !== 1'b1 || bus.ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_req: got cpu_rst_n=%b loading=%b ram_we=%b, required 0/1/0",
               bus.cpu_rst_n, bus.loading, bus.ram_we);
    end
    tick();
    bus.cpu_we = 1'b0;
    wait_tx("boot_req_prompt", 20, used);
  endtask

  task automatic test_bad_checksum();
    pl_q = '{8'hAA, 8'hBB};
    send_frame("bad_csum", 8'h00);
    @(negedge clk);
    n_tests++;
    if (bus.err !== 1'b1 || bus.cpu_rst_n !== 1'b0 || bus.state !== S_SYNC) begin
      n_fail++;
      $display("FAIL bad_csum_status: got err=%b cpu_rst_n=%b state=%0d, required 1/0/%0d",
               bus.err, bus.cpu_rst_n, bus.state, S_SYNC);
    end
    tick();
    pl_q = '{8'h7F};
    send_frame("recover", 8'h7F);
    @(negedge clk);
    n_tests++;
    if (bus.err !== 1'b0 || bus.state !== S_RUN) begin
      n_fail++;
      $display("FAIL recover_status: got err=%b state=%0d, required 0/%0d", bus.err, bus.state, S_RUN);
    end
    tick();
  endtask

  task automatic test_zero_len();
    pl_q.delete();
    send_frame("zero_len", 8'h00);
    @(negedge clk);
    n_tests++;
    if (bus.state !== S_RUN || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_status: got state=%0d err=%b, required %0d/0", bus.state, bus.err, S_RUN);
    end
    tick();
  endtask

  task automatic test_timeout();
    int used;
    exp_ram_q.push_back({16'h0000, 8'h01});
    exp_ram_q.push_back({16'h0001, 8'h02});
    exp_tx_q.push_back(B_NAK);
    send_byte(8'h55);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    wait_tx("timeout", 200, used);
    n_tests++;
    if (used < TO || used > TO + 5) begin
      n_fail++;
      $display("FAIL timeout_delay: got %0d cycles of silence, required %0d..%0d", used, TO, TO + 5);
    end
    @(negedge clk);
    n_tests++;
    if (bus.err !== 1'b1 || bus.state !== S_SYNC) begin
      n_fail++;
      $display("FAIL timeout_status: got err=%b state=%0d, required 1/%0d", bus.err, bus.state, S_SYNC);
    end
    tick();
    send_byte(8'h12);
    repeat (3) tick();
    @(negedge clk);
    n_tests++;
    if (bus.state !== S_SYNC) begin
      n_fail++;
      $display("FAIL after_timeout_byte: got state=%0d, required %0d", bus.state, S_SYNC);
    end
    tick();
  endtask

  task automatic test_reset_mid_data();
    logic [15:0] obs, expv;
    int          used;
    exp_ram_q.push_back({16'h0000, 8'hC3});
    send_byte(8'h55);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'hC3);
    repeat (2) tick();
    n_tests++;
    if (bus.state !== S_DATA) begin
      n_fail++;
      $display("FAIL mid_data_state: got %0d, required %0d", bus.state, S_DATA);
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs  = {bus.tx_start, bus.tx_data, bus.ram_we, bus.cpu_rst_n, bus.err, bus.loading, bus.state};
    expv = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, S_PROMPT};
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL async_reset: got %h, required %h", obs, expv);
    end
    tick();
    rst_n = 1'b1;
    exp_tx_q.push_back(PR);
    wait_tx("reset_prompt", 20, used);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.boot_req  = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = 8'h00;

    test_reset();
    test_good_frame();
    test_boot_req();
    test_bad_checksum();
    test_boot_req();
    test_zero_len();
    test_boot_req();
    test_timeout();
    test_reset_mid_data();

    repeat (3) tick();
    n_tests++;
    if (exp_ram_q.size() != 0 || exp_tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: got %0d writes and %0d tx bytes pending, required 0",
               exp_ram_q.size(), exp_tx_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
